// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
package regfile_pkg;

   typedef enum logic [0:0] {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } rf_state_e;

   localparam int RF_DATA_WIDTH = 32;
   localparam int RF_ADDR_WIDTH = 5;
   localparam int RF_NUM_RD     = 2;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks every register index once after reset or on
// request, emitting a zero-write strobe per cycle and a done pulse at the end.
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear_req,
   output logic                  busy,
   output logic                  clear_done,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_idx
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

   rf_state_e             state_r;
   rf_state_e             state_nxt_s;
   logic [ADDR_WIDTH-1:0] idx_r;
   logic [ADDR_WIDTH-1:0] idx_nxt_s;
   logic                  done_r;
   logic                  done_nxt_s;

   // State, index and done-pulse registers; reset always restarts a clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= RF_CLEAR;
         idx_r   <= {ADDR_WIDTH{1'b0}};
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         idx_r   <= idx_nxt_s;
         done_r  <= done_nxt_s;
      end
   end

   // Next-state logic; a request while clearing is ignored, never restarts.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      done_nxt_s  = 1'b0;
      case (state_r)
         RF_IDLE: begin
            if (clear_req) begin
               state_nxt_s = RF_CLEAR;
               idx_nxt_s   = {ADDR_WIDTH{1'b0}};
            end else begin
               state_nxt_s = RF_IDLE;
            end
         end
         RF_CLEAR: begin
            if (idx_r == LAST_IDX) begin
               state_nxt_s = RF_IDLE;
               idx_nxt_s   = {ADDR_WIDTH{1'b0}};
               done_nxt_s  = 1'b1;
            end else begin
               idx_nxt_s   = idx_r + ADDR_WIDTH'(1);
            end
         end
         default: begin
            state_nxt_s = RF_CLEAR;
            idx_nxt_s   = {ADDR_WIDTH{1'b0}};
         end
      endcase
   end

   assign busy       = (state_r == RF_CLEAR);
   assign clr_we     = busy;
   assign clr_idx    = idx_r;
   assign clear_done = done_r;

endmodule

// File: rtl/mp_register_file.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised writes
// (wr1 wins), optional hardwired zero. Define REGFILE_BYPASS_EN for write-first reads.
module mp_register_file
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int NUM_RD     = RF_NUM_RD,
   parameter int ZERO_REG   = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_sel,
   output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
   input  logic                         wr0_en,
   input  logic [ADDR_WIDTH-1:0]        wr0_addr,
   input  logic [DATA_WIDTH-1:0]        wr0_data,
   input  logic                         wr1_en,
   input  logic [ADDR_WIDTH-1:0]        wr1_addr,
   input  logic [DATA_WIDTH-1:0]        wr1_data,
   input  logic                         clear_req,
   output logic                         busy,
   output logic                         clear_done,
   output logic                         wr_collision
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic                  busy_s;
   logic                  clr_we_s;
   logic [ADDR_WIDTH-1:0] clr_idx_s;
   logic                  wr0_ok_s;
   logic                  wr1_ok_s;
   logic                  collision_s;
   logic                  wr_collision_r;

   regfile_clear_fsm #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_fsm (
      .clk        (clk),
      .reset      (reset),
      .clear_req  (clear_req),
      .busy       (busy_s),
      .clear_done (clear_done),
      .clr_we     (clr_we_s),
      .clr_idx    (clr_idx_s)
   );

   // A write port is effective only when idle and not aimed at a hardwired zero.
   assign wr0_ok_s    = wr0_en && !busy_s && !((ZERO_REG != 0) && (wr0_addr == ADDR_ZERO));
   assign wr1_ok_s    = wr1_en && !busy_s && !((ZERO_REG != 0) && (wr1_addr == ADDR_ZERO));
   assign collision_s = wr0_ok_s && wr1_ok_s && (wr0_addr == wr1_addr);

   // Storage array: clear strobe first, then wr0, with wr1 overriding on a tie.
   always_ff @(posedge clk) begin
      if (clr_we_s) begin
         mem_r[clr_idx_s] <= {DATA_WIDTH{1'b0}};
      end else begin
         if (wr0_ok_s) begin
            mem_r[wr0_addr] <= wr0_data;
         end
         if (wr1_ok_s) begin
            mem_r[wr1_addr] <= wr1_data;
         end
      end
   end

   // Collision flag, high for the single cycle after the colliding edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_collision_r <= 1'b0;
      end else begin
         wr_collision_r <= collision_s;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] sel_s;
      logic [DATA_WIDTH-1:0] lane_s;

      assign sel_s = rd_sel[p*ADDR_WIDTH +: ADDR_WIDTH];

      // Read mux: busy and zero register force 0; bypass matches wr1 before wr0.
      always_comb begin
         lane_s = {DATA_WIDTH{1'b0}};
         if (busy_s) begin
            lane_s = {DATA_WIDTH{1'b0}};
         end else if ((ZERO_REG != 0) && (sel_s == ADDR_ZERO)) begin
            lane_s = {DATA_WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
         end else if (wr1_ok_s && (wr1_addr == sel_s)) begin
            lane_s = wr1_data;
         end else if (wr0_ok_s && (wr0_addr == sel_s)) begin
            lane_s = wr0_data;
`endif
         end else begin
            lane_s = mem_r[sel_s];
         end
      end

      assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = lane_s;
   end

   assign busy         = busy_s;
   assign wr_collision = wr_collision_r;

endmodule

// File: tb/tb_mp_register_file.sv
// Directed, table-driven bench for mp_register_file (default 32x32, two read ports).
module tb_mp_register_file;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int DEPTH = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR*AW-1:0] rd_sel;
   logic [NR*DW-1:0] rd_data;
   logic             wr0_en, wr1_en;
   logic [AW-1:0]    wr0_addr, wr1_addr;
   logic [DW-1:0]    wr0_data, wr1_data;
   logic             clear_req;
   logic             busy, clear_done, wr_collision;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mp_register_file #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_RD     (NR),
      .ZERO_REG   (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rd_sel       (rd_sel),
      .rd_data      (rd_data),
      .wr0_en       (wr0_en),
      .wr0_addr     (wr0_addr),
      .wr0_data     (wr0_data),
      .wr1_en       (wr1_en),
      .wr1_addr     (wr1_addr),
      .wr1_data     (wr1_data),
      .clear_req    (clear_req),
      .busy         (busy),
      .clear_done   (clear_done),
      .wr_collision (wr_collision)
   );

   typedef struct {
      logic          w0e;
      logic [AW-1:0] w0a;
      logic [DW-1:0] w0d;
      logic          w1e;
      logic [AW-1:0] w1a;
      logic [DW-1:0] w1d;
      logic [AW-1:0] r0;
      logic [AW-1:0] r1;
      logic [DW-1:0] e0;
      logic [DW-1:0] e1;
      logic          ec;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] lane(input int p);
      return rd_data[p*DW +: DW];
   endfunction

   // Counts DEPTH edges from the current point, expecting busy until the last.
   task automatic expect_clear(input string tag);
      for (int e = 1; e <= DEPTH; e++) begin
         tick;
         if (e < DEPTH) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_done_early"}, {31'd0, clear_done}, 32'd0);
            chk({tag, "_rd_zero"}, lane(0), 32'd0);
            chk({tag, "_coll"}, {31'd0, wr_collision}, 32'd0);
         end else begin
            wr0_en = 1'b0;
            wr1_en = 1'b0;
            chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
            chk({tag, "_done"}, {31'd0, clear_done}, 32'd1);
         end
      end
      tick;
      chk({tag, "_done_pulse"}, {31'd0, clear_done}, 32'd0);
   endtask

   task automatic expect_all_zero(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         rd_sel = {AW'(DEPTH - 1 - i), AW'(i)};
         #1;
         chk($sformatf("%s_r%0d", tag, i), lane(0), 32'd0);
         chk($sformatf("%s_r%0d", tag, DEPTH - 1 - i), lane(1), 32'd0);
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      vecs[1] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'h0,        5'd0,  5'd5, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2] = '{1'b1, 5'd7,  32'h00001111, 1'b1, 5'd7,  32'h00002222, 5'd7,  5'd5, 32'h00002222, 32'hDEADBEEF, 1'b1};
      vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd7, 32'h00002222, 32'h00002222, 1'b0};
      vecs[4] = '{1'b1, 5'd0,  32'h0000AAAA, 1'b1, 5'd0,  32'h0000BBBB, 5'd0,  5'd7, 32'h0,        32'h00002222, 1'b0};
      vecs[5] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd1,  32'h00000001, 5'd31, 5'd1, 32'hCAFEF00D, 32'h00000001, 1'b0};
      vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  32'h0BADF00D, 5'd2,  5'd31, 32'h0BADF00D, 32'hCAFEF00D, 1'b0};
      vecs[7] = '{1'b1, 5'd9,  32'h11111111, 1'b0, 5'd0,  32'h0,        5'd9,  5'd7, 32'h11111111, 32'h00002222, 1'b0};
      vecs[8] = '{1'b1, 5'd7,  32'h00003333, 1'b1, 5'd8,  32'h00004444, 5'd7,  5'd8, 32'h00003333, 32'h00004444, 1'b0};

      reset     = 1'b0;
      rd_sel    = {AW'(5), AW'(5)};
      wr0_en    = 1'b0; wr0_addr = 5'd0; wr0_data = 32'd0;
      wr1_en    = 1'b0; wr1_addr = 5'd0; wr1_data = 32'd0;
      clear_req = 1'b0;

      // Reset state and power-up clear.
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_done", {31'd0, clear_done}, 32'd0);
      chk("rst_coll", {31'd0, wr_collision}, 32'd0);
      chk("rst_rd", lane(0), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      expect_clear("init");
      expect_all_zero("init_zero");

      // Table-driven write/read vectors (reads taken with writes already off).
      for (int i = 0; i < 9; i++) begin
         wr0_en = vecs[i].w0e; wr0_addr = vecs[i].w0a; wr0_data = vecs[i].w0d;
         wr1_en = vecs[i].w1e; wr1_addr = vecs[i].w1a; wr1_data = vecs[i].w1d;
         rd_sel = {vecs[i].r1, vecs[i].r0};
         tick;
         wr0_en = 1'b0;
         wr1_en = 1'b0;
         #1;
         chk($sformatf("vec%0d_rd0", i), lane(0), vecs[i].e0);
         chk($sformatf("vec%0d_rd1", i), lane(1), vecs[i].e1);
         chk($sformatf("vec%0d_coll", i), {31'd0, wr_collision}, {31'd0, vecs[i].ec});
      end

      // Same-cycle read of a register being written.
      wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hA5A5A5A5;
      rd_sel = {AW'(9), AW'(9)};
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass_same_cycle", lane(0), 32'hA5A5A5A5);
`else
      chk("rbw_same_cycle", lane(0), 32'h11111111);
`endif
      tick;
      wr0_en = 1'b0;
      #1;
      chk("bypass_next_cycle", lane(1), 32'hA5A5A5A5);

      // Fill r1..r31, then clear on request with writes hammered during busy.
      for (int i = 1; i < DEPTH; i++) begin
         wr0_en = 1'b1; wr0_addr = AW'(i); wr0_data = i * 32'h01010101;
         tick;
      end
      wr0_en = 1'b0;
      rd_sel = {AW'(17), AW'(31)};
      #1;
      chk("fill_r31", lane(0), 32'h1F1F1F1F);
      chk("fill_r17", lane(1), 32'h11111111);
      clear_req = 1'b1;
      tick;
      clear_req = 1'b0;
      wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hFFFF0000;
      wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h0000EEEE;
      chk("req_busy", {31'd0, busy}, 32'd1);
      expect_clear("req");
      expect_all_zero("req_zero");

      // Reset in the middle of a clear restarts it from index 0.
      clear_req = 1'b1;
      tick;
      clear_req = 1'b0;
      repeat (10) tick;
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd1);
      chk("mid_rst_done", {31'd0, clear_done}, 32'd0);
      tick;
      tick;
      @(negedge clk);
      reset = 1'b1;
      expect_clear("restart");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
